// File: rtl/cuberoot_bcd_display_if.sv
// Handshake and display bundle for the cube-root BCD display stage.
// The master drives start/value; the slave returns status and the segment/anode drive.
interface cuberoot_bcd_display_if #(
  parameter int DIGITS = 4
);
  logic              start;
  logic [31:0]       value;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  modport master (output start, value, input busy, done, overflow, seg, an);
  modport slave  (input start, value, output busy, done, overflow, seg, an);
endinterface

// File: rtl/cuberoot_bcd_display.sv
// Binary-to-BCD (double-dabble, one bit/clock) and multiplexed 7-segment display driver.
// Latency: 34 cycles from accepted start to next accept; done pulses 33 cycles after accept.
// Backpressure: start is taken only while idle; requests during a conversion are dropped.
module cuberoot_bcd_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cuberoot_bcd_display_if.slave  bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SC_W  = $clog2(SCAN_DIV);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_nxt;
  logic [31:0]         sh;
  logic [39:0]         bcd;
  logic [38:0]         bcd_adj;
  logic [5:0]          cnt;
  logic [4*DIGITS-1:0] disp;
  logic                overflow;
  logic                done;
  logic [SC_W-1:0]     sc;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] disp_upper;
  logic [3:0]          nib;
  logic                blank;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (cnt == 6'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Top digit of a 32-bit value never exceeds 4, so nibble 9 needs no correction.
  always_comb begin
    bcd_adj = bcd[38:0];
    for (int i = 0; i < 9; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= '0;
      bcd      <= '0;
      cnt      <= '0;
      disp     <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh  <= bus.value;
            bcd <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          bcd <= {bcd_adj, sh[31]};
          sh  <= {sh[30:0], 1'b0};
          cnt <= cnt + 6'd1;
        end
        DONE: begin
          disp     <= bcd[4*DIGITS-1:0];
          overflow <= |(bcd >> (4*DIGITS));
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc  <= '0;
      idx <= '0;
    end else if (sc == SC_LAST) begin
      sc  <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      sc <= sc + 1'b1;
    end
  end

  // seg/an decode only registered state, so both switch on the idx edge together.
  always_comb begin
    disp_upper = disp >> (4 * idx);
    nib        = disp_upper[3:0];
    blank      = (idx != '0) && (disp_upper == '0);
  end

  assign bus.seg      = overflow ? 7'b0111111 : (blank ? 7'b1111111 : glyph(nib));
  assign bus.an       = ~(DIGITS'(1) << idx);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done;
  assign bus.overflow = overflow;

endmodule
